// File: rtl/uart_pkg.sv
// uart_pkg: shared UART defaults, RX state encoding and counter width
package uart_pkg;
  localparam int CLK_FREQ_DEF = 50000000;
  localparam int UART_BPS_DEF = 9600;
  localparam int UART_CNT_W = 16;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_rx_state_t;
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 3-flop synchroniser (reset to idle-high) with falling-edge detect
module uart_rx_sync (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic uart_rxd,
  output logic rxd_sync,
  output logic start_edge
);
  logic rxd_s0, rxd_s1, rxd_s2;
  always_ff @(posedge sys_clk or negedge sys_rst)
    if (!sys_rst) {rxd_s0, rxd_s1, rxd_s2} <= 3'b111;
    else {rxd_s0, rxd_s1, rxd_s2} <= {uart_rxd, rxd_s0, rxd_s1};
  assign rxd_sync = rxd_s1;
  assign start_edge = rxd_s2 & ~rxd_s1;
endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 LSB-first receiver with mid-bit sampling, done strobe and framing-error strobe
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = CLK_FREQ_DEF,
  parameter int UART_BPS = UART_BPS_DEF
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       uart_rxd,
  output logic [7:0] uart_data,
  output logic       uart_done,
  output logic       frame_err,
  output logic       rx_busy
);
  localparam int BPS_CNT = CLK_FREQ / UART_BPS;
  localparam logic [UART_CNT_W-1:0] MID = UART_CNT_W'(BPS_CNT / 2);
  localparam logic [UART_CNT_W-1:0] LAST = UART_CNT_W'(BPS_CNT - 1);
  uart_rx_state_t state_q, state_d;
  logic [UART_CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d, data_d;
  logic done_d, err_d, rxd_sync, start_edge;
  uart_rx_sync u_sync (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .uart_rxd  (uart_rxd),
    .rxd_sync  (rxd_sync),
    .start_edge(start_edge)
  );
  wire at_mid = cnt_q == MID;
  wire at_last = cnt_q == LAST;
  wire [UART_CNT_W-1:0] cnt_inc = at_last ? '0 : cnt_q + 1'b1;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    shift_d = shift_q;
    data_d = uart_data;
    done_d = 1'b0;
    err_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        state_d = start_edge ? START : IDLE;
      end
      START: begin
        cnt_d = cnt_inc;
        if (at_mid && rxd_sync) begin
          state_d = IDLE;
          cnt_d = '0;
        end else if (at_last) begin
          idx_d = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        cnt_d = cnt_inc;
        if (at_mid) shift_d[idx_q] = rxd_sync;
        if (at_last) begin
          state_d = idx_q == 3'd7 ? STOP : DATA;
          idx_d = idx_q + 3'd1;
        end
      end
      default: begin
        cnt_d = cnt_inc;
        // leave at mid-stop so a back-to-back start bit is not missed
        if (at_mid) begin
          state_d = IDLE;
          cnt_d = '0;
          data_d = rxd_sync ? shift_q : uart_data;
          done_d = rxd_sync;
          err_d = ~rxd_sync;
        end
      end
    endcase
  end
  always_ff @(posedge sys_clk or negedge sys_rst)
    if (!sys_rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      shift_q <= '0;
      uart_data <= '0;
      uart_done <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      shift_q <= shift_d;
      uart_data <= data_d;
      uart_done <= done_d;
      frame_err <= err_d;
    end
  assign rx_busy = state_q != IDLE;
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed checks of uart_receiver at 16 clocks per bit
module tb_uart_receiver;
  logic sys_clk = 1'b0;
  logic sys_rst = 1'b0;
  logic uart_rxd = 1'b1;
  logic [7:0] uart_data;
  logic uart_done, frame_err, rx_busy;
  int checks = 0, failures = 0;
  int cyc = 0, done_cnt = 0, err_cnt = 0, busy_cnt = 0, both_cnt = 0;
  int done_cyc[$], err_cyc[$];
  logic [7:0] done_data[$];
  int c0, c1, d0, e0;
  uart_receiver #(.CLK_FREQ(1000000), .UART_BPS(62500)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .uart_rxd (uart_rxd),
    .uart_data(uart_data),
    .uart_done(uart_done),
    .frame_err(frame_err),
    .rx_busy  (rx_busy)
  );
  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;
  always @(negedge sys_clk) begin
    if (uart_done) begin
      done_cnt++;
      done_cyc.push_back(cyc);
      done_data.push_back(uart_data);
    end
    if (frame_err) begin
      err_cnt++;
      err_cyc.push_back(cyc);
    end
    if (rx_busy) busy_cnt++;
    if (uart_done && frame_err) both_cnt++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wait_clks(input int n);
    repeat (n) @(negedge sys_clk);
  endtask
  task automatic send_frame(input logic [7:0] b, input logic stop, output int start_cyc);
    start_cyc = cyc;
    uart_rxd = 1'b0;
    wait_clks(16);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      wait_clks(16);
    end
    uart_rxd = stop;
    wait_clks(16);
    uart_rxd = 1'b1;
  endtask
  initial begin
    wait_clks(5);
    chk("rst_data", 32'(uart_data), 32'h00);
    chk("rst_done", 32'(uart_done), 32'h0);
    chk("rst_err", 32'(frame_err), 32'h0);
    chk("rst_busy", 32'(rx_busy), 32'h0);
    sys_rst = 1'b1;
    wait_clks(5);
    // single frame
    send_frame(8'hA5, 1'b1, c0);
    wait_clks(4);
    chk("single_done_cnt", 32'(done_cnt), 32'd1);
    chk("single_done_cyc", 32'(done_cyc[0]), 32'(c0 + 156));
    chk("single_data", 32'(done_data[0]), 32'hA5);
    chk("single_no_err", 32'(err_cnt), 32'd0);
    // back-to-back
    send_frame(8'h00, 1'b1, c0);
    send_frame(8'hFF, 1'b1, c1);
    wait_clks(4);
    chk("b2b_done_cnt", 32'(done_cnt), 32'd3);
    chk("b2b_gap", 32'(done_cyc[2] - done_cyc[1]), 32'd160);
    chk("b2b_cyc0", 32'(done_cyc[1]), 32'(c0 + 156));
    chk("b2b_data0", 32'(done_data[1]), 32'h00);
    chk("b2b_data1", 32'(done_data[2]), 32'hFF);
    // start glitch
    wait_clks(10);
    busy_cnt = 0;
    uart_rxd = 1'b0;
    wait_clks(4);
    uart_rxd = 1'b1;
    wait_clks(40);
    chk("glitch_busy_cycles", 32'(busy_cnt), 32'd9);
    chk("glitch_no_done", 32'(done_cnt), 32'd3);
    chk("glitch_no_err", 32'(err_cnt), 32'd0);
    // framing error then good frame
    send_frame(8'h3C, 1'b0, c0);
    wait_clks(20);
    chk("ferr_cnt", 32'(err_cnt), 32'd1);
    chk("ferr_cyc", 32'(err_cyc[0]), 32'(c0 + 156));
    chk("ferr_no_done", 32'(done_cnt), 32'd3);
    chk("ferr_data_kept", 32'(uart_data), 32'hFF);
    send_frame(8'h3C, 1'b1, c0);
    wait_clks(4);
    chk("ferr_next_done", 32'(done_cnt), 32'd4);
    chk("ferr_next_data", 32'(uart_data), 32'h3C);
    // break: line held low
    uart_rxd = 1'b0;
    wait_clks(400);
    uart_rxd = 1'b1;
    wait_clks(40);
    chk("break_err_cnt", 32'(err_cnt), 32'd2);
    chk("break_no_done", 32'(done_cnt), 32'd4);
    chk("break_data_kept", 32'(uart_data), 32'h3C);
    chk("break_idle", 32'(rx_busy), 32'h0);
    // reset during data bit 4
    d0 = done_cnt;
    e0 = err_cnt;
    uart_rxd = 1'b0;
    wait_clks(16);
    for (int i = 0; i < 4; i++) begin
      uart_rxd = i[0];
      wait_clks(16);
    end
    uart_rxd = 1'b1;
    wait_clks(8);
    sys_rst = 1'b0;
    wait_clks(2);
    chk("mid_rst_data", 32'(uart_data), 32'h00);
    chk("mid_rst_done", 32'(uart_done), 32'h0);
    chk("mid_rst_err", 32'(frame_err), 32'h0);
    chk("mid_rst_busy", 32'(rx_busy), 32'h0);
    wait_clks(3);
    sys_rst = 1'b1;
    wait_clks(200);
    chk("abort_no_done", 32'(done_cnt), 32'(d0));
    chk("abort_no_err", 32'(err_cnt), 32'(e0));
    send_frame(8'h5A, 1'b1, c0);
    wait_clks(4);
    chk("after_rst_done", 32'(done_cnt), 32'(d0 + 1));
    chk("after_rst_cyc", 32'(done_cyc[done_cyc.size() - 1]), 32'(c0 + 156));
    chk("after_rst_data", 32'(uart_data), 32'h5A);
    chk("never_both", 32'(both_cnt), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
